piano_voice: RTL and testbench

Parametrised single-voice tone engine for the electric piano. It takes the debounced, active-low key levels from the matrix keyboard scanner and selects the lowest-index pressed key. It generates that note's square wave with octave shift, glitch-free note changes and an optional release sustain. It replaces the combinational key-to-beeper path between the keyboard scanner and the piezo output pin.

---
 rtl/piano_pkg.sv | 27 ++
 rtl/key_priority_enc.sv | 23 ++
 rtl/piano_voice.sv | 153 +++++++++++++++
 tb/tb_piano_voice.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared constants and elaboration-time helpers for the piano tone engine.
package piano_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;

  // Note frequencies in centi-Hz, C4 upward in semitones
  localparam int unsigned FREQ_CHZ [16] = '{
    26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200,
    41530, 44000, 46616, 49388, 52325, 55437, 58733, 62225
  };

  // Half-period in clock cycles for key k at octave 0 (floor division)
  function automatic int unsigned half_period(input longint unsigned clk_hz,
                                              input logic [3:0]        k);
    return 32'((clk_hz * 64'd50) / 64'(FREQ_CHZ[k]));
  endfunction

  // Number of clock cycles the tone is held after the last release
  function automatic int unsigned sustain_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned ms);
    return 32'(ms * (clk_hz / 64'd1000));
  endfunction

endpackage

// File: rtl/key_priority_enc.sv
// Lowest-index-wins encoder for the active-low key levels.
module key_priority_enc import piano_pkg::*; #(
  parameter int KEYS = 16
) (
  input  logic [KEYS-1:0]                          key_n,
  output logic                                     any,
  output logic [((KEYS > 1) ? $clog2(KEYS) : 1)-1:0] sel
);

  localparam int IDX_W = (KEYS > 1) ? $clog2(KEYS) : 1;

  // Scan from the top down so the lowest pressed key is written last
  always_comb begin
    any = |(~key_n);
    sel = '0;
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (!key_n[k]) begin
        sel = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/piano_voice.sv
// Single-voice square-wave tone engine with octave shift and release sustain.
module piano_voice import piano_pkg::*; #(
  parameter int KEYS       = 16,
  parameter int CLK_HZ     = 12_000_000,
  parameter int SUSTAIN_MS = 200,
  parameter int DIV_W      = 18
) (
  input  logic                                       clk_in,
  input  logic                                       rst_n_in,
  input  logic [KEYS-1:0]                            key_n,
  input  logic [1:0]                                 octave,
  input  logic                                       sustain_en,
  output logic                                       piano_out,
  output logic                                       note_active,
  output logic [((KEYS > 1) ? $clog2(KEYS) : 1)-1:0] note_idx
);

  localparam int          IDX_W   = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int unsigned SUS_CYC = sustain_cycles(CLK_HZ, SUSTAIN_MS);
  localparam int          SUS_W   = $clog2(SUS_CYC + 1);

  // Constant half-period ROM; all division happens at elaboration
  function automatic logic [KEYS-1:0][DIV_W-1:0] build_rom();
    logic [KEYS-1:0][DIV_W-1:0] rom;
    for (int k = 0; k < KEYS; k++) begin
      rom[k] = DIV_W'(half_period(CLK_HZ, 4'(k)));
    end
    return rom;
  endfunction

  localparam logic [KEYS-1:0][DIV_W-1:0] HALF_ROM = build_rom();

  // Counter reload value: ROM entry shifted by octave (3 behaves as 2), minus one
  function automatic logic [DIV_W-1:0] reload_val(input logic [IDX_W-1:0] k,
                                                  input logic [1:0]       o);
    logic [1:0] eff;
    eff = (o == 2'd3) ? 2'd2 : o;
    return (HALF_ROM[k] >> eff) - 1'b1;
  endfunction

  logic             any;
  logic [IDX_W-1:0] sel;

  logic [1:0]       state_q,  state_d;
  logic [DIV_W-1:0] cnt_q,    cnt_d;
  logic             out_q,    out_d;
  logic             active_q, active_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [1:0]       oct_q,    oct_d;
  logic [SUS_W-1:0] stimer_q, stimer_d;

  key_priority_enc #(.KEYS(KEYS)) u_enc (
    .key_n (key_n),
    .any   (any),
    .sel   (sel)
  );

  // Tone engine plus IDLE/PLAY/SUSTAIN transitions; note changes land only on toggles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    idx_d    = idx_q;
    oct_d    = oct_q;
    stimer_d = stimer_q;

    if (state_q != ST_IDLE) begin
      if (cnt_q == '0) begin
        out_d = ~out_q;
        if (state_q == ST_PLAY && any) begin
          cnt_d = reload_val(sel, octave);
          idx_d = sel;
          oct_d = octave;
        end else begin
          cnt_d = reload_val(idx_q, oct_q);
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        out_d = 1'b0;
        cnt_d = '0;
        if (any) begin
          state_d = ST_PLAY;
          out_d   = 1'b1;
          cnt_d   = reload_val(sel, octave);
          idx_d   = sel;
          oct_d   = octave;
        end
      end
      ST_PLAY: begin
        if (!any) begin
          if (sustain_en) begin
            state_d  = ST_SUSTAIN;
            stimer_d = SUS_W'(SUS_CYC - 1);
          end else begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      ST_SUSTAIN: begin
        if (any) begin
          state_d = ST_PLAY;
        end else if (!sustain_en || stimer_q == '0) begin
          state_d  = ST_IDLE;
          out_d    = 1'b0;
          cnt_d    = '0;
          stimer_d = '0;
        end else begin
          stimer_d = stimer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State registers, cleared immediately on reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      active_q <= 1'b0;
      idx_q    <= '0;
      oct_q    <= 2'd0;
      stimer_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      oct_q    <= oct_d;
      stimer_q <= stimer_d;
    end
  end

  assign piano_out   = out_q;
  assign note_active = active_q;
  assign note_idx    = idx_q;

endmodule

// File: tb/tb_piano_voice.sv
// Directed bench for piano_voice; SUSTAIN_MS=1 so the hold is 12000 cycles.
// Half-periods: floor(600000000/FREQ_CHZ[k]) >> octave
//   key0: 22933 (oct1 11466, oct2 5733), key2 oct2: 5107, key3 oct2: 4821
module tb_piano_voice;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_n;
  logic [1:0]  octave;
  logic        sustain_en;
  logic        piano_out;
  logic        note_active;
  logic [3:0]  note_idx;

  int totalChecks = 0;
  int badChecks   = 0;
  int n;

  piano_voice #(
    .KEYS       (16),
    .CLK_HZ     (12_000_000),
    .SUSTAIN_MS (1),
    .DIV_W      (18)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .key_n       (key_n),
    .octave      (octave),
    .sustain_en  (sustain_en),
    .piano_out   (piano_out),
    .note_active (note_active),
    .note_idx    (note_idx)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input int expected);
    totalChecks++;
    if (observed !== 32'(expected)) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic [1:0] oct,
                               input logic sus);
    key_n      = keys;
    octave     = oct;
    sustain_en = sus;
  endtask

  // Counts negedges until piano_out leaves 'level'; optionally changes inputs at count actAt
  task automatic countLevel(input logic level, input int limit, input int actAt,
                            input logic [15:0] actKeys, input logic [1:0] actOct,
                            output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == actAt) applyStimulus(actKeys, actOct, sustain_en);
    end while (piano_out === level && cnt < limit);
  endtask

  initial begin
    // Reset held with a key pressed
    rst_n = 1'b0;
    applyStimulus(16'hFFFE, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_out", piano_out, 0);
    checkOutput("rst_active", note_active, 0);
    checkOutput("rst_idx", note_idx, 0);
    applyStimulus(16'hFFFF, 2'd0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_out", piano_out, 0);

    // Single key, octave 0, then octave 1 selected mid half-period
    applyStimulus(16'hFFFE, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("press_out", piano_out, 1);
    checkOutput("press_active", note_active, 1);
    checkOutput("press_idx", note_idx, 0);
    countLevel(1'b1, 30000, 100, 16'hFFFE, 2'd1, n);
    checkOutput("oct0_high", n, 22933);
    countLevel(1'b0, 30000, -1, 16'hFFFE, 2'd1, n);
    checkOutput("oct1_low", n, 11466);

    // Release during a high half without sustain
    applyStimulus(16'hFFFF, 2'd1, 1'b0);
    @(negedge clk);
    checkOutput("rel_out", piano_out, 0);
    checkOutput("rel_active", note_active, 0);
    @(negedge clk);

    // Keys 0 and 2 at octave 3 (acts as 2); drop key 0 mid half-period
    applyStimulus(16'hFFFA, 2'd3, 1'b0);
    @(negedge clk);
    checkOutput("prio_out", piano_out, 1);
    checkOutput("prio_idx0", note_idx, 0);
    countLevel(1'b1, 30000, 1000, 16'hFFFB, 2'd3, n);
    checkOutput("prio_high", n, 5733);
    checkOutput("prio_idx2", note_idx, 2);
    countLevel(1'b0, 30000, -1, 16'hFFFB, 2'd3, n);
    checkOutput("prio_low", n, 5107);
    applyStimulus(16'hFFFF, 2'd3, 1'b0);
    @(negedge clk);
    checkOutput("rel2_out", piano_out, 0);
    checkOutput("rel2_active", note_active, 0);
    @(negedge clk);

    // Sustain: release right after the first rise, tone runs 12000 cycles
    applyStimulus(16'hFFFB, 2'd2, 1'b1);
    @(negedge clk);
    checkOutput("sus_press_out", piano_out, 1);
    applyStimulus(16'hFFFF, 2'd2, 1'b1);
    countLevel(1'b1, 30000, -1, 16'hFFFF, 2'd2, n);
    checkOutput("sus_high", n, 5107);
    checkOutput("sus_active", note_active, 1);
    countLevel(1'b0, 30000, -1, 16'hFFFF, 2'd2, n);
    checkOutput("sus_low", n, 5107);
    countLevel(1'b1, 30000, -1, 16'hFFFF, 2'd2, n);
    checkOutput("sus_tail", n, 1787);
    checkOutput("sus_end_active", note_active, 0);
    @(negedge clk);

    // Sustain then re-press key 3 at cycle 5000: phase kept, new note on next toggle
    applyStimulus(16'hFFFB, 2'd2, 1'b1);
    @(negedge clk);
    checkOutput("rp_out", piano_out, 1);
    applyStimulus(16'hFFFF, 2'd2, 1'b1);
    countLevel(1'b1, 30000, 5000, 16'hFFF7, 2'd2, n);
    checkOutput("rp_high", n, 5107);
    checkOutput("rp_idx", note_idx, 3);
    checkOutput("rp_active", note_active, 1);
    countLevel(1'b0, 30000, -1, 16'hFFF7, 2'd2, n);
    checkOutput("rp_low", n, 4821);

    // Async reset while sustaining, checked before any clock edge
    applyStimulus(16'hFFFF, 2'd2, 1'b1);
    repeat (50) @(negedge clk);
    checkOutput("arst_pre_active", note_active, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out", piano_out, 0);
    checkOutput("arst_active", note_active, 0);
    checkOutput("arst_idx", note_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'hFFFE, 2'd2, 1'b1);
    @(negedge clk);
    checkOutput("restart_out", piano_out, 1);
    checkOutput("restart_idx", note_idx, 0);
    countLevel(1'b1, 30000, -1, 16'hFFFE, 2'd2, n);
    checkOutput("restart_high", n, 5733);
    applyStimulus(16'hFFFF, 2'd2, 1'b0);
    @(negedge clk);
    checkOutput("final_active", note_active, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
